fir_coef_sram_ctrl: RTL and testbench
=====================================

# fir_coef_sram_ctrl

Sequencer and arbiter for the FIR filter's 10x16 single-port coefficient SRAM. On each input-sample strobe it sweeps all ten coefficient addresses and streams the read data, with its tap index, to the MAC datapath. Between sweeps it grants single-word coefficient writes from the host update port. It sits between the sample-rate control logic, the host register interface, the SRAM and the MAC.

## Interface
Parameters:
- P_NUM_TAP, 10, number of coefficients/taps swept per sample
- P_ADDR_W, 4, SRAM address width
- P_DATA_W, 16, coefficient width

Ports (single clock; reset is synchronous and active-high):
- iClk12M  in  1  system clock
- iRst  in  1  synchronous reset, active-high
- iEnSample  in  1  new-sample strobe; starts one coefficient sweep
- iCoefUpdReq  in  1  host write request; level, held until oCoefUpdAck
- iCoefUpdAddr  in  P_ADDR_W  host write address
- iCoefUpdData  in  P_DATA_W  host write data
- oCoefUpdAck  out  1  one-cycle pulse; request consumed
- oUpdErr  out  1  one-cycle pulse with ack; address ≥ P_NUM_TAP, no write issued
- oCsnRam  out  1  SRAM chip select, active-low
- oWrnRam  out  1  SRAM write enable, active-low
- oAddrRam  out  P_ADDR_W  SRAM address
- oWtDtRam  out  P_DATA_W  SRAM write data
- iRdDtRam  in  P_DATA_W  SRAM registered read data
- oCoef  out  P_DATA_W  coefficient to MAC; iRdDtRam when oCoefVld, else 0
- oCoefIdx  out  P_ADDR_W  tap index of oCoef
- oCoefVld  out  1  oCoef/oCoefIdx valid
- oSweepDone  out  1  one-cycle pulse alongside the last coefficient (idx P_NUM_TAP-1)
- oSmpOvr  out  1  one-cycle pulse; iEnSample arrived while not IDLE and was dropped
- oBusy  out  1  state != IDLE

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE.
- In IDLE, on iEnSample: go to READ with cnt=0. iEnSample has priority over a simultaneous iCoefUpdReq, which stays pending.
- In IDLE with iCoefUpdReq and no iEnSample: go to WRITE.
- READ drives oCsnRam=0, oWrnRam=1, oAddrRam=cnt.
  - cnt increments each cycle.
  - After cnt=P_NUM_TAP-1, go to DRAIN.
- DRAIN issues no RAM access. It presents the final coefficient, then returns to IDLE.
- WRITE lasts one cycle, then returns to IDLE. It pulses oCoefUpdAck.
  - Address < P_NUM_TAP: oCsnRam=0, oWrnRam=0, with address and data registered from the request.
  - Address ≥ P_NUM_TAP: oCsnRam=1, and oUpdErr pulses with the ack.
- iEnSample seen in READ/DRAIN/WRITE is dropped and oSmpOvr pulses the next cycle. No queueing.
- Idle RAM outputs: oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0.
- A write never interleaves with a sweep. A sweep is never aborted except by reset.
- Counter wrap: cnt is cleared on entering READ and never exceeds P_NUM_TAP-1.

## Timing
- All outputs are registered, except oCoef (gated passthrough of iRdDtRam).
- Sample edge E0 is the edge where iEnSample is captured in IDLE.
- Read address k is driven in cycle E_k..E_k+1, for k=0..9.
- The RAM returns data after E_k+1. oCoefVld=1 and oCoefIdx=k hold in cycles E1..E10, one coefficient per cycle, with no gaps.
- oSweepDone coincides with idx 9 (cycle E10, DRAIN).
- State is IDLE after E11. The minimum iEnSample spacing is 12 cycles.
- Write: request captured at edge W0. The RAM write strobe and oCoefUpdAck occur in cycle W0..W1. State is back to IDLE after W1. The host must drop iCoefUpdReq in the cycle after the ack or a second write occurs.
- Reset: iRst at any edge forces IDLE with cnt=0. All outputs go to 0, except oCsnRam=1 and oWrnRam=1.
  - An in-flight sweep is abandoned with no oSweepDone.
  - An in-flight write is not acked.

## Structure
- Shared package fir_ctrl_pkg holds:
  - the state enum (IDLE/READ/DRAIN/WRITE)
  - P_NUM_TAP, P_ADDR_W and P_DATA_W defaults
  - the RAM-idle constants
- Single module with no sub-modules. The tap counter and the valid/index delay stage are inline.

## Test plan
- Reset, then idle 5 cycles -> oCsnRam=1, oWrnRam=1, oBusy=0, all other outputs 0.
- Write coefs 0x0101*k to addr k (k=0..9), then iEnSample -> oCoefVld for 10 consecutive cycles; idx 0..9 with oCoef 0x0000, 0x0101, …, 0x0909; oSweepDone with idx 9 at E10.
- iEnSample and iCoefUpdReq (addr 3, 0x7FFF) in the same IDLE cycle -> full sweep first; ack at E11+1; the next sweep shows idx3=0x7FFF.
- iEnSample again at E5 and at E11 -> oSmpOvr pulses for each, the sweep is uninterrupted, and a strobe at E12 starts a new sweep.
- iCoefUpdReq addr 0xA -> ack and oUpdErr pulse together, oCsnRam stays 1, and RAM contents are unchanged.
- iRst at E4 of a sweep -> IDLE next cycle, oCoefVld=0, no oSweepDone; a subsequent iEnSample produces a clean 10-coefficient sweep.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared definitions for the FIR coefficient SRAM controller:
//   - default tap count, SRAM address and data widths
//   - controller state encoding (IDLE / READ / DRAIN / WRITE)
//   - SRAM control levels driven when no access is in progress
// ----------------------------------------------------------------------------
package fir_ctrl_pkg;

    // Default geometry of the coefficient store: 10 taps x 16 bits
    localparam int NUM_TAP_DEF = 10;
    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } ctrlState_t;

    // SRAM strobes are active-low; "idle" means deselected, not writing.
    // Idle address and write data are all-zero.
    localparam logic RAM_CSN_IDLE = 1'b1;
    localparam logic RAM_WRN_IDLE = 1'b1;

endpackage

// File: rtl/fir_coef_sram_ctrl.sv
// ----------------------------------------------------------------------------
// fir_coef_sram_ctrl
// Sequencer/arbiter for the FIR coefficient single-port SRAM.
// On every iEnSample seen in IDLE it reads all P_NUM_TAP coefficients in
// ascending order and streams them (with tap index) to the MAC. Between
// sweeps it services single-word host writes.
//
// Ports:
//   iClk12M, iRst          clock, synchronous active-high reset
//   iEnSample              sample strobe, starts one sweep
//   iCoefUpdReq/Addr/Data  host write request (level, held until ack)
//   oCoefUpdAck, oUpdErr   one-cycle ack; oUpdErr when address out of range
//   oCsnRam, oWrnRam,
//   oAddrRam, oWtDtRam     SRAM controls (registered)
//   iRdDtRam               SRAM registered read data
//   oCoef, oCoefIdx,
//   oCoefVld, oSweepDone   coefficient stream to the MAC
//   oSmpOvr                strobe dropped because the controller was busy
//   oBusy                  controller not in IDLE
// ----------------------------------------------------------------------------
module fir_coef_sram_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int P_NUM_TAP = fir_ctrl_pkg::NUM_TAP_DEF,
    parameter int P_ADDR_W  = fir_ctrl_pkg::ADDR_W_DEF,
    parameter int P_DATA_W  = fir_ctrl_pkg::DATA_W_DEF
) (
    input  logic                iClk12M,
    input  logic                iRst,
    input  logic                iEnSample,
    input  logic                iCoefUpdReq,
    input  logic [P_ADDR_W-1:0] iCoefUpdAddr,
    input  logic [P_DATA_W-1:0] iCoefUpdData,
    output logic                oCoefUpdAck,
    output logic                oUpdErr,
    output logic                oCsnRam,
    output logic                oWrnRam,
    output logic [P_ADDR_W-1:0] oAddrRam,
    output logic [P_DATA_W-1:0] oWtDtRam,
    input  logic [P_DATA_W-1:0] iRdDtRam,
    output logic [P_DATA_W-1:0] oCoef,
    output logic [P_ADDR_W-1:0] oCoefIdx,
    output logic                oCoefVld,
    output logic                oSweepDone,
    output logic                oSmpOvr,
    output logic                oBusy
);

    localparam logic [P_ADDR_W-1:0] LAST_TAP  = P_ADDR_W'(P_NUM_TAP - 1);
    localparam logic [P_ADDR_W:0]   NUM_TAP_W = (P_ADDR_W + 1)'(P_NUM_TAP);

    ctrlState_t          state;
    logic [P_ADDR_W-1:0] cnt;
    logic                updAddrOk;

    assign updAddrOk = {1'b0, iCoefUpdAddr} < NUM_TAP_W;

    // Read data is already registered by the SRAM; only gate it so the MAC
    // sees zero outside a valid slot.
    assign oCoef = oCoefVld ? iRdDtRam : '0;

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state       <= IDLE;
            cnt         <= '0;
            oCsnRam     <= RAM_CSN_IDLE;
            oWrnRam     <= RAM_WRN_IDLE;
            oAddrRam    <= '0;
            oWtDtRam    <= '0;
            oCoefUpdAck <= 1'b0;
            oUpdErr     <= 1'b0;
            oCoefIdx    <= '0;
            oCoefVld    <= 1'b0;
            oSweepDone  <= 1'b0;
            oSmpOvr     <= 1'b0;
            oBusy       <= 1'b0;
        end else begin
            // Pulses and RAM controls default to their idle levels each
            // cycle; the state branches below override them.
            oCsnRam     <= RAM_CSN_IDLE;
            oWrnRam     <= RAM_WRN_IDLE;
            oAddrRam    <= '0;
            oWtDtRam    <= '0;
            oCoefUpdAck <= 1'b0;
            oUpdErr     <= 1'b0;
            oCoefIdx    <= '0;
            oCoefVld    <= 1'b0;
            oSweepDone  <= 1'b0;
            // Strobes are not queued: anything arriving mid-operation is
            // dropped and flagged one cycle later.
            oSmpOvr     <= iEnSample && (state != IDLE);

            case (state)
                IDLE: begin
                    // Sample strobe wins; a simultaneous write request stays
                    // pending and is taken when the sweep has finished.
                    if (iEnSample) begin
                        state   <= READ;
                        cnt     <= '0;
                        oCsnRam <= 1'b0;
                        oBusy   <= 1'b1;
                    end else if (iCoefUpdReq) begin
                        state       <= WRITE;
                        oBusy       <= 1'b1;
                        oCoefUpdAck <= 1'b1;
                        if (updAddrOk) begin
                            oCsnRam  <= 1'b0;
                            oWrnRam  <= 1'b0;
                            oAddrRam <= iCoefUpdAddr;
                            oWtDtRam <= iCoefUpdData;
                        end else begin
                            oUpdErr <= 1'b1;
                        end
                    end
                end

                READ: begin
                    // Address cnt was on the bus last cycle; its data
                    // appears now, so tag the slot with cnt.
                    oCoefVld <= 1'b1;
                    oCoefIdx <= cnt;
                    if (cnt == LAST_TAP) begin
                        state      <= DRAIN;
                        oSweepDone <= 1'b1;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        oCsnRam  <= 1'b0;
                        oAddrRam <= cnt + 1'b1;
                    end
                end

                // Last coefficient is on the output during this cycle.
                DRAIN: begin
                    state <= IDLE;
                    cnt   <= '0;
                    oBusy <= 1'b0;
                end

                WRITE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fir_coef_sram_ctrl
// Drives fir_coef_sram_ctrl against a behavioural SRAM and a reference
// coefficient table; every sweep is compared slot-by-slot with the table.
// ----------------------------------------------------------------------------
module tb_fir_coef_sram_ctrl;

    localparam int NT = 10;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          iClk12M = 1'b0;
    logic          iRst = 1'b1;
    logic          iEnSample = 1'b0;
    logic          iCoefUpdReq = 1'b0;
    logic [AW-1:0] iCoefUpdAddr = '0;
    logic [DW-1:0] iCoefUpdData = '0;
    logic          oCoefUpdAck, oUpdErr, oCsnRam, oWrnRam;
    logic [AW-1:0] oAddrRam;
    logic [DW-1:0] oWtDtRam;
    logic [DW-1:0] iRdDtRam;
    logic [DW-1:0] oCoef;
    logic [AW-1:0] oCoefIdx;
    logic          oCoefVld, oSweepDone, oSmpOvr, oBusy;

    fir_coef_sram_ctrl #(.P_NUM_TAP(NT), .P_ADDR_W(AW), .P_DATA_W(DW)) dut (
        .iClk12M     (iClk12M),
        .iRst        (iRst),
        .iEnSample   (iEnSample),
        .iCoefUpdReq (iCoefUpdReq),
        .iCoefUpdAddr(iCoefUpdAddr),
        .iCoefUpdData(iCoefUpdData),
        .oCoefUpdAck (oCoefUpdAck),
        .oUpdErr     (oUpdErr),
        .oCsnRam     (oCsnRam),
        .oWrnRam     (oWrnRam),
        .oAddrRam    (oAddrRam),
        .oWtDtRam    (oWtDtRam),
        .iRdDtRam    (iRdDtRam),
        .oCoef       (oCoef),
        .oCoefIdx    (oCoefIdx),
        .oCoefVld    (oCoefVld),
        .oSweepDone  (oSweepDone),
        .oSmpOvr     (oSmpOvr),
        .oBusy       (oBusy)
    );

    always #5 iClk12M = ~iClk12M;

    // Behavioural single-port SRAM with registered read data
    logic [DW-1:0] ram [16];
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 16'hDEAD;
        iRdDtRam = '0;
    end
    always @(posedge iClk12M) begin
        if (!oCsnRam) begin
            if (!oWrnRam) ram[oAddrRam] <= oWtDtRam;
            else          iRdDtRam      <= ram[oAddrRam];
        end
    end

    // Reference: what each tap should hold after the writes issued so far
    logic [DW-1:0] refCoef [NT];

    int nErr = 0;
    int nChk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk12M);
        @(negedge iClk12M);
    endtask

    // Wait (bounded) for the ack of a request already on the bus; expects
    // it in the first cycle after capture, then checks the strobes.
    task automatic waitAck(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bit ok = (a < NT);
        do begin
            tick();
            n++;
        end while (!oCoefUpdAck && n < 30);
        check("ackLat", n, 1);
        check("ackErr", {31'd0, oUpdErr}, {31'd0, !ok});
        check("wrCsn", {31'd0, oCsnRam}, {31'd0, !ok});
        check("wrWrn", {31'd0, oWrnRam}, {31'd0, !ok});
        if (ok) begin
            check("wrAddr", {28'd0, oAddrRam}, {28'd0, a});
            check("wrData", {16'd0, oWtDtRam}, {16'd0, d});
            refCoef[a] = d;
        end
        iCoefUpdReq = 1'b0;
        tick();
        check("ackPulse", {31'd0, oCoefUpdAck}, 0);
        check("wrIdle", {31'd0, oBusy}, 0);
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        iCoefUpdReq  = 1'b1;
        iCoefUpdAddr = a;
        iCoefUpdData = d;
        waitAck(a, d);
    endtask

    // One full sweep starting at the next edge (E0). Extra strobes are
    // applied at edges ovrA/ovrB (1..11) and must be reported as overruns.
    // Returns in cycle E11..E12.
    task automatic runSweep(input int ovrA, input int ovrB);
        iEnSample = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            bit vld;
            tick();
            vld = (k >= 1 && k <= 10);
            check("vld", {31'd0, oCoefVld}, {31'd0, vld});
            check("idx", {28'd0, oCoefIdx}, vld ? 32'(k - 1) : 32'd0);
            check("coef", {16'd0, oCoef}, vld ? {16'd0, refCoef[k-1]} : 32'd0);
            check("done", {31'd0, oSweepDone}, {31'd0, k == 10});
            check("rdCsn", {31'd0, oCsnRam}, {31'd0, k > 9});
            check("rdWrn", {31'd0, oWrnRam}, 1);
            check("rdAddr", {28'd0, oAddrRam}, (k <= 9) ? 32'(k) : 32'd0);
            check("busy", {31'd0, oBusy}, {31'd0, k <= 10});
            check("ovr", {31'd0, oSmpOvr}, {31'd0, k >= 1 && (k == ovrA || k == ovrB)});
            check("noAck", {31'd0, oCoefUpdAck}, 0);
            if (k < 11) iEnSample = (k + 1 == ovrA) || (k + 1 == ovrB);
        end
        iEnSample = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int doneSeen;
        int vldSeen;
        for (int i = 0; i < NT; i++) refCoef[i] = 16'hDEAD;

        // Reset, then 5 idle cycles
        tick();
        tick();
        iRst = 1'b0;
        repeat (5) tick();
        check("rstCsn", {31'd0, oCsnRam}, 1);
        check("rstWrn", {31'd0, oWrnRam}, 1);
        check("rstBusy", {31'd0, oBusy}, 0);
        check("rstBus", {oAddrRam, oWtDtRam, oCoefIdx, 8'd0}, 0);
        check("rstOuts", {26'd0, oCoefUpdAck, oUpdErr, oCoef != 0, oCoefVld, oSweepDone, oSmpOvr}, 0);

        // Load 0x0101*k and sweep
        for (int k = 0; k < NT; k++) doWrite(AW'(k), DW'(16'h0101 * k));
        runSweep(-1, -1);
        tick();

        // Sweep and write request in the same IDLE cycle: sweep first
        iCoefUpdReq  = 1'b1;
        iCoefUpdAddr = 4'd3;
        iCoefUpdData = 16'h7FFF;
        runSweep(-1, -1);
        waitAck(4'd3, 16'h7FFF);
        runSweep(-1, -1);

        // Overrun strobes at E5 and E11, then a strobe at E12 starts a sweep
        tick();
        runSweep(5, 11);
        runSweep(-1, -1);

        // Out-of-range write: error, no RAM write, table unchanged
        tick();
        doWrite(4'hA, 16'h1234);
        doWrite(4'hF, 16'h5678);
        check("ramOob", {16'd0, ram[10]}, 32'hDEAD);
        runSweep(-1, -1);

        // Reset at E4 of a sweep
        tick();
        iEnSample = 1'b1;
        tick();
        iEnSample = 1'b0;
        repeat (3) tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("abVld", {31'd0, oCoefVld}, 0);
        check("abDone", {31'd0, oSweepDone}, 0);
        check("abBusy", {31'd0, oBusy}, 0);
        check("abCsn", {31'd0, oCsnRam}, 1);
        doneSeen = 0;
        vldSeen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            doneSeen += int'(oSweepDone);
            vldSeen  += int'(oCoefVld);
        end
        check("abNoDone", doneSeen, 0);
        check("abNoVld", vldSeen, 0);
        runSweep(-1, -1);

        // Randomized mix of writes (some out of range) and sweeps
        for (int it = 0; it < 40; it++) begin
            tick();
            if ($urandom_range(0, 1) == 0) begin
                doWrite(AW'($urandom_range(0, 15)), DW'($urandom));
            end else if ($urandom_range(0, 2) == 0) begin
                runSweep(int'($urandom_range(1, 11)), -1);
            end else begin
                runSweep(-1, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
